// File: rtl/serial_adder_if.sv
// Handshake/operand bundle for serial_adder.
// SERIAL_ADDER_SUB_EN adds the SUB request bit.
interface serial_adder_if #(
  parameter int WIDTH = 8
);
  logic             START;
  logic [WIDTH-1:0] A;
  logic [WIDTH-1:0] B;
  logic             CIN;
`ifdef SERIAL_ADDER_SUB_EN
  logic             SUB;
`endif
  logic [WIDTH-1:0] S;
  logic             C;
  logic             BUSY;
  logic             DONE;

  modport master (
    output START, A, B, CIN,
`ifdef SERIAL_ADDER_SUB_EN
    output SUB,
`endif
    input  S, C, BUSY, DONE
  );

  modport slave (
    input  START, A, B, CIN,
`ifdef SERIAL_ADDER_SUB_EN
    input  SUB,
`endif
    output S, C, BUSY, DONE
  );
endinterface

// File: rtl/serial_adder.sv
// Multi-cycle adder: STEP-bit full-adder slice per clock with a registered carry.
// Optional SERIAL_ADDER_SUB_EN adds A-B (A + ~B + 1) selected by SUB.
module serial_adder #(
  parameter int WIDTH = 8,
  parameter int STEP  = 1
) (
  input  logic           CLK,
  input  logic           RST,
  serial_adder_if.slave  bus
);
  localparam int N     = WIDTH / STEP;
  localparam int CNT_W = (N > 1) ? $clog2(N) : 1;

  if (WIDTH < 1 || STEP < 1 || (WIDTH % STEP) != 0) begin : g_bad_cfg
    $error("serial_adder: STEP must be >= 1 and divide WIDTH exactly");
  end

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  state_t             state_q, state_d;
  logic [WIDTH-1:0]   a_q, a_d;
  logic [WIDTH-1:0]   b_q, b_d;
  logic [WIDTH-1:0]   sum_q, sum_d;
  logic               carry_q, carry_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [WIDTH-1:0]   s_q, s_d;
  logic               c_q, c_d;

  logic               accept;
  logic               last_slice;
  logic [STEP-1:0]    slice_sum;
  logic               slice_cout;

  // START is only honoured outside BUSY; DONE accepts like IDLE for back-to-back use.
  assign accept     = bus.START && (state_q != ST_BUSY);
  assign last_slice = (cnt_q == CNT_W'(N - 1));

  // Operands shift right so the active slice always sits in the low STEP bits.
  assign {slice_cout, slice_sum} = {1'b0, a_q[STEP-1:0]}
                                 + {1'b0, b_q[STEP-1:0]}
                                 + (STEP+1)'(carry_q);

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= ST_IDLE;
      a_q     <= '0;
      b_q     <= '0;
      sum_q   <= '0;
      carry_q <= 1'b0;
      cnt_q   <= '0;
      s_q     <= '0;
      c_q     <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      sum_q   <= sum_d;
      carry_q <= carry_d;
      cnt_q   <= cnt_d;
      s_q     <= s_d;
      c_q     <= c_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (bus.START) state_d = ST_BUSY;
      ST_BUSY: if (last_slice) state_d = ST_DONE;
      ST_DONE: state_d = bus.START ? ST_BUSY : ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    a_d     = a_q;
    b_d     = b_q;
    sum_d   = sum_q;
    carry_d = carry_q;
    cnt_d   = cnt_q;
    s_d     = s_q;
    c_d     = c_q;
    if (accept) begin
      a_d   = bus.A;
      cnt_d = '0;
`ifdef SERIAL_ADDER_SUB_EN
      b_d     = bus.SUB ? ~bus.B : bus.B;
      carry_d = bus.SUB ? 1'b1 : bus.CIN;
`else
      b_d     = bus.B;
      carry_d = bus.CIN;
`endif
    end else if (state_q == ST_BUSY) begin
      a_d   = a_q >> STEP;
      b_d   = b_q >> STEP;
      // New slice enters at the top; after N slices the sum is fully aligned.
      sum_d = sum_q >> STEP;
      sum_d[WIDTH-1 -: STEP] = slice_sum;
      carry_d = slice_cout;
      cnt_d   = cnt_q + CNT_W'(1);
      if (last_slice) begin
        s_d = sum_d;
        c_d = slice_cout;
      end
    end
  end

  always_comb begin
    bus.S    = s_q;
    bus.C    = c_q;
    bus.BUSY = (state_q == ST_BUSY);
    bus.DONE = (state_q == ST_DONE);
  end
endmodule

// File: doc/serial_adder.md
Name: serial_adder

Overview:
- Parametrised, multi-cycle successor to the single-bit half adder.
- Adds two WIDTH-bit operands plus a carry-in, STEP bits per clock, using a STEP-bit full-adder slice and a registered carry between slices.
- Uses a START/BUSY/DONE handshake and holds the result until the next operation completes.
- Intended as the arithmetic building block for the upcoming multi-cycle ALU assignments, where area matters more than latency.

Parameters:
- WIDTH, 8, operand and sum width in bits. Must be ≥ 1.
- STEP, 1, bits processed per clock. Must divide WIDTH exactly; an elaboration-time check fails otherwise.

Ports:
- CLK, input, 1, rising-edge clock.
- RST, input, 1, synchronous active-high reset.
- START, input, 1, request a new addition. Sampled only in IDLE or DONE.
- A, input, WIDTH, operand A. Sampled with START.
- B, input, WIDTH, operand B. Sampled with START.
- CIN, input, 1, carry-in. Sampled with START.
- S, output, WIDTH, sum result. Registered.
- C, output, 1, carry-out result. Registered.
- BUSY, output, 1, high while slices are being computed.
- DONE, output, 1, one-cycle pulse when S/C are updated.

Behaviour:
- One clock, CLK. Reset is synchronous and active-high on RST; the polarity and synchronicity are fixed.
- Reset: state=IDLE; S=0, C=0, BUSY=0, DONE=0; operand, carry and slice-counter registers cleared.
- RST has priority over every other input at any state, including mid-operation. The partial result is discarded and S/C return to 0.
- States: IDLE, BUSY, DONE. The encoding is free.
- IDLE:
  - START=1 at an edge latches A, B and CIN, clears the slice counter, and moves to BUSY.
  - START=0 stays in IDLE.
- BUSY: at each edge, slice k (bits k·STEP .. k·STEP+STEP-1) is added with the registered carry. The slice sum is written into the internal sum register and the carry register is updated. k then increments.
- Let N = WIDTH/STEP.
  - The edge that processes slice N-1 copies the internal sum to S and the final carry to C, and moves to DONE.
  - BUSY=1 for exactly N cycles.
- DONE:
  - DONE=1 for exactly one cycle, BUSY=0.
  - START=1 in this cycle is accepted exactly as in IDLE (back-to-back operations, no bubble). Otherwise the next state is IDLE.
- Latency: START sampled at edge t gives DONE=1 in the cycle following edge t+N, with S/C valid from that same edge.
- Throughput: one result per N+1 cycles.
- START while BUSY is ignored. Operand inputs are don't-care outside the sampling edge.
- S/C hold their last result through IDLE and through the BUSY cycles of the next operation. They change only at the final-slice edge or on reset.
- Arithmetic: the result is {C,S} = A + B + CIN modulo 2^(WIDTH+1). No truncation or sign handling.
- STEP=WIDTH degenerates to N=1: one BUSY cycle, then DONE.

Optional Feature:
- Macro: SERIAL_ADDER_SUB_EN.
- When defined:
  - An extra input port SUB (1 bit) is added and is sampled with START.
  - SUB=1 computes A − B as A + ~B + 1. CIN is ignored and the internal carry is seeded with 1.
  - C is then the not-borrow flag: C=1 when A ≥ B unsigned.
  - SUB=0 behaves exactly as the base block.
- When not defined:
  - There is no SUB port.
  - The block is pure addition and its timing is identical to the base block.

Test Plan:
- Reset mid-operation (WIDTH=8, STEP=1): START with A=0x5A, B=0xA5, CIN=1, then RST=1 after 3 BUSY cycles. Required: next cycle state=IDLE, S=0x00, C=0, BUSY=0. No DONE pulse follows.
- Basic add and latency (WIDTH=8, STEP=1): A=0x5A, B=0xA5, CIN=1, START at edge t. Required: BUSY=1 for 8 cycles, DONE=1 only in the cycle after edge t+8, S=0x00, C=1.
- Carry propagation (WIDTH=8, STEP=1): A=0xFF, B=0x01, CIN=0. Required: S=0x00, C=1. Then A=0x12, B=0x34, CIN=0 gives S=0x46, C=0.
- START during BUSY (WIDTH=8, STEP=1): pulse START with A=0x01, B=0x01 mid-BUSY of a 0x0F+0x01 operation. Required: it is ignored; the result is S=0x10, C=0, with exactly one DONE pulse.
- Back-to-back operations (WIDTH=8, STEP=4): START held high continuously with A=0x80, B=0x80, then A=0x03, B=0x04. Required: DONE pulses 3 cycles apart; results are S=0x00, C=1, then S=0x07, C=0.
- Subtraction with SERIAL_ADDER_SUB_EN defined (WIDTH=8, STEP=2):
  - A=0x10, B=0x01, SUB=1 gives S=0x0F, C=1.
  - A=0x01, B=0x02, SUB=1, CIN=1 gives S=0xFF, C=0.
